// File: rtl/calc_unit.sv
// calc_unit: 16-bit accumulator calculator driven by a 32-bit RISC-V-style ALU
//   clk  - system clock, state changes on rising edge
//   btnu - asynchronous active-low reset, clears the accumulator
//   btnl/btnc/btnr - operation select {msb, mid, lsb}
//   btnd - level-sensitive execute enable
//   sw   - operand B
//   led  - accumulator value
module calc_unit (
  input  logic        clk,
  input  logic        btnu,
  input  logic        btnc,
  input  logic        btnl,
  input  logic        btnr,
  input  logic        btnd,
  input  logic [15:0] sw,
  output logic [15:0] led
);
  logic [15:0] acc_q, acc_d;
  logic [31:0] a, b, res;
  logic [4:0]  sh;
  logic [2:0]  op;
  assign op = {btnl, btnc, btnr};
  assign a  = {{16{acc_q[15]}}, acc_q};
  assign b  = {{16{sw[15]}}, sw};
  assign sh = b[4:0];
  always_comb begin
    res = 32'd0;
    case (op)
      3'b000:  res = a & b;
      3'b001:  res = a | b;
      3'b010:  res = a + b;
      3'b011:  res = a - b;
      3'b100:  res = {31'd0, $signed(a) < $signed(b)};
      3'b101:  res = a << sh;
      3'b110:  res = $unsigned($signed(a) >>> sh);
      default: res = a ^ b;
    endcase
    acc_d = btnd ? res[15:0] : acc_q;
  end
  always_ff @(posedge clk or negedge btnu)
    if (!btnu) acc_q <= 16'h0000;
    else acc_q <= acc_d;
  assign led = acc_q;
endmodule

// File: tb/tb_calc_unit.sv
// tb_calc_unit: directed scoreboard bench for calc_unit
module tb_calc_unit;
  logic clk = 1'b0;
  logic btnu = 1'b1, btnc = 1'b0, btnl = 1'b0, btnr = 1'b0, btnd = 1'b0;
  logic [15:0] sw = 16'h0000;
  logic [15:0] led;
  logic [15:0] acc_m;
  logic [15:0] q[$];
  int compared = 0, mismatched = 0;

  calc_unit dut (.clk(clk), .btnu(btnu), .btnc(btnc), .btnl(btnl), .btnr(btnr),
                 .btnd(btnd), .sw(sw), .led(led));

  always #5 clk = ~clk;

  function automatic logic [15:0] model(input logic [15:0] acc, input logic [2:0] op, input logic [15:0] s);
    int unsigned n;
    n = s[4:0];
    case (op)
      3'd0: return acc & s;
      3'd1: return acc | s;
      3'd2: return acc + s;
      3'd3: return acc - s;
      3'd4: return ($signed(acc) < $signed(s)) ? 16'd1 : 16'd0;
      3'd5: return (n >= 16) ? 16'h0000 : acc << n;
      3'd6: return (n >= 16) ? {16{acc[15]}} : $unsigned($signed(acc) >>> n);
      default: return acc ^ s;
    endcase
  endfunction

  task automatic check(input string tag, input logic [15:0] exp);
    compared++;
    assert (led === exp) else begin
      mismatched++;
      $error("FAIL %s: led=%h expected=%h", tag, led, exp);
    end
  endtask

  task automatic check_pop(input string tag);
    if (q.size() == 0) begin
      compared++;
      mismatched++;
      $error("FAIL %s: scoreboard empty, led=%h", tag, led);
    end else check(tag, q.pop_front());
  endtask

  task automatic do_op(input string tag, input logic [2:0] op, input logic [15:0] s, input int n);
    @(negedge clk);
    {btnl, btnc, btnr} = op;
    sw = s;
    btnd = 1'b1;
    for (int i = 0; i < n; i++) begin
      acc_m = model(acc_m, op, s);
      q.push_back(acc_m);
      @(posedge clk);
      #1 check_pop(tag);
    end
    btnd = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 btnu = 1'b0;
    #1 check("reset_async", 16'h0000);
    acc_m = 16'h0000;
    q.delete();
    @(negedge clk);
    btnu = 1'b1;
  endtask

  initial begin
    acc_m = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 btnu = 1'b0;
    #1 check("reset_immediate", 16'h0000);
    btnd = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("reset_held", 16'h0000);
    btnd = 1'b0;
    @(negedge clk) btnu = 1'b1;
    @(posedge clk);
    #1 check("reset_release", 16'h0000);
    do_op("add1", 3'b010, 16'h354a, 1);
    do_op("sub", 3'b011, 16'h1234, 1);
    do_op("or", 3'b001, 16'h1001, 1);
    do_op("and", 3'b000, 16'hf0f0, 1);
    do_op("xor", 3'b111, 16'h1fa2, 1);
    do_op("add2", 3'b010, 16'h6aa2, 1);
    do_op("sll4", 3'b101, 16'h0004, 1);
    do_op("sra1", 3'b110, 16'h0001, 1);
    do_op("slt_neg", 3'b100, 16'h46ff, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      {btnl, btnc, btnr} = 3'(i + 2);
      sw = 16'(16'h1357 * (i + 1));
      @(posedge clk);
      #1 check("hold", acc_m);
    end
    do_reset();
    do_op("add_level", 3'b010, 16'h0001, 3);
    check("add_level_final", 16'h0003);
    do_reset();
    do_op("add_7fff", 3'b010, 16'h7fff, 1);
    do_op("add_wrap", 3'b010, 16'h0001, 1);
    check("wrap_8000", 16'h8000);
    do_reset();
    do_op("sub_wrap", 3'b011, 16'h0001, 1);
    check("wrap_ffff", 16'hffff);
    do_reset();
    do_op("set1", 3'b010, 16'h0001, 1);
    do_op("slt_pos", 3'b100, 16'hffff, 1);
    do_reset();
    do_op("set1b", 3'b010, 16'h0001, 1);
    do_op("sll16", 3'b101, 16'h0010, 1);
    do_op("set8000", 3'b010, 16'h8000, 1);
    do_op("sra16", 3'b110, 16'hfff0, 1);
    check("sra16_ffff", 16'hffff);
    do_reset();
    do_op("pre_mid", 3'b010, 16'h0003, 1);
    @(negedge clk);
    {btnl, btnc, btnr} = 3'b010;
    sw = 16'h0001;
    btnd = 1'b1;
    acc_m = model(acc_m, 3'b010, 16'h0001);
    q.push_back(acc_m);
    @(posedge clk);
    #1 check_pop("mid_step");
    #2 btnu = 1'b0;
    #1 check("mid_reset", 16'h0000);
    acc_m = 16'h0000;
    btnd = 1'b0;
    @(negedge clk) btnu = 1'b1;
    do_op("after_reset", 3'b010, 16'h0005, 1);
    check("after_reset_val", 16'h0005);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
